// File: rtl/ddr3_upload_arbiter_if.sv
// Upload-side bus between the requesters, the arbiter and the DDR3 write channel.
// master = requester/channel side, slave = arbiter.
interface ddr3_upload_arbiter_if #(
    parameter int NREQ = 3
);
    logic [NREQ-1:0][27:0] req_addr;
    logic [NREQ-1:0][7:0]  req_din;
    logic [NREQ-1:0]       req_upload;
    logic [NREQ-1:0]       req_wr;
    logic [NREQ-1:0]       req_ready;
    logic [NREQ-1:0]       grant;
    logic [27:0]           ddr3_addr;
    logic [7:0]            ddr3_din;
    logic                  ddr3_upload;
    logic                  ddr3_wr;
    logic                  ddr3_ready;
    logic                  wr_err;

    modport master (
        output req_addr, req_din, req_upload, req_wr, ddr3_ready,
        input  req_ready, grant, ddr3_addr, ddr3_din, ddr3_upload, ddr3_wr, wr_err
    );

    modport slave (
        input  req_addr, req_din, req_upload, req_wr, ddr3_ready,
        output req_ready, grant, ddr3_addr, ddr3_din, ddr3_upload, ddr3_wr, wr_err
    );
endinterface

// File: rtl/ddr3_upload_arbiter.sv
// Round-robin arbiter granting one upload session at a time onto the DDR3 write channel.
// Optional DDR3_ARB_TIMEOUT_EN: idle-grant watchdog with sticky timeout_flag output.
//
// state   | meaning
// IDLE    | no owner, pick next requester round-robin from rr_ptr
// GRANT   | one requester owns the channel, signals muxed through
// RELEASE | one dead cycle, rr_ptr advances past the last owner
module ddr3_upload_arbiter #(
    parameter int          NREQ           = 3,
    parameter logic [15:0] TIMEOUT_CYCLES = 16'hFFFF
) (
    input  logic                    clk,
    input  logic                    reset,
`ifdef DDR3_ARB_TIMEOUT_EN
    output logic                    timeout_flag,
`endif
    ddr3_upload_arbiter_if.slave    bus
);
    localparam int PW = (NREQ > 2) ? $clog2(NREQ) : 1;

    typedef enum logic [1:0] {IDLE, GRANT, RELEASE} state_t;

    state_t          state;
    logic [NREQ-1:0] grant_q;
    logic            upload_q;
    logic            wr_err_q;
    logic [PW-1:0]   rr_ptr;
    logic [PW-1:0]   gidx;
    logic [PW-1:0]   next_idx;
    logic            any_req;
    logic            time_up;
    logic [27:0]     addr_mux;
    logic [7:0]      din_mux;

    // First requesting index at or after rr_ptr, wrapping modulo NREQ.
    always_comb begin
        next_idx = '0;
        any_req  = 1'b0;
        for (int i = 0; i < NREQ; i++) begin
            int c;
            c = int'(rr_ptr) + i;
            if (c >= NREQ) c = c - NREQ;
            if (!any_req && bus.req_upload[c]) begin
                any_req  = 1'b1;
                next_idx = PW'(c);
            end
        end
    end

    always_comb begin
        addr_mux = '0;
        din_mux  = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant_q[i]) begin
                addr_mux = addr_mux | bus.req_addr[i];
                din_mux  = din_mux  | bus.req_din[i];
            end
        end
    end

    assign bus.grant       = grant_q;
    assign bus.ddr3_upload = upload_q;
    assign bus.wr_err      = wr_err_q;
    assign bus.ddr3_addr   = addr_mux;
    assign bus.ddr3_din    = din_mux;
    assign bus.ddr3_wr     = |(bus.req_wr & grant_q);
    assign bus.req_ready   = grant_q & {NREQ{bus.ddr3_ready}};

`ifdef DDR3_ARB_TIMEOUT_EN
    localparam logic [15:0] TMR_LOAD = TIMEOUT_CYCLES - 16'd1;
    logic [15:0] tmr;
    logic        to_flag_q;
    assign time_up      = (tmr == 16'd0) && !bus.ddr3_wr;
    assign timeout_flag = to_flag_q;
`else
    assign time_up = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state    <= IDLE;
            grant_q  <= '0;
            upload_q <= 1'b0;
            wr_err_q <= 1'b0;
            rr_ptr   <= '0;
            gidx     <= '0;
`ifdef DDR3_ARB_TIMEOUT_EN
            tmr       <= '0;
            to_flag_q <= 1'b0;
`endif
        end else begin
            if (|(bus.req_wr & ~grant_q)) wr_err_q <= 1'b1;
            case (state)
                IDLE: begin
                    if (any_req) begin
                        state    <= GRANT;
                        grant_q  <= {{(NREQ-1){1'b0}}, 1'b1} << next_idx;
                        upload_q <= 1'b1;
                        gidx     <= next_idx;
`ifdef DDR3_ARB_TIMEOUT_EN
                        tmr <= TMR_LOAD;
`endif
                    end
                end
                GRANT: begin
                    if (!bus.req_upload[gidx] || time_up) begin
                        state    <= RELEASE;
                        grant_q  <= '0;
                        upload_q <= 1'b0;
                    end
`ifdef DDR3_ARB_TIMEOUT_EN
                    // Down-counter reloads on every forwarded write.
                    if (time_up)           to_flag_q <= 1'b1;
                    else if (bus.ddr3_wr)  tmr <= TMR_LOAD;
                    else                   tmr <= tmr - 16'd1;
`endif
                end
                RELEASE: begin
                    state  <= IDLE;
                    rr_ptr <= (gidx == PW'(NREQ-1)) ? '0 : gidx + 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_ddr3_upload_arbiter.sv
// Directed vector table plus hand-written sequences for ddr3_upload_arbiter (NREQ=3).
module tb_ddr3_upload_arbiter;
    localparam logic [27:0] A0 = 28'h1400000;
    localparam logic [27:0] A1 = 28'h2000010;
    localparam logic [27:0] A2 = 28'h3000020;

    logic clk = 1'b0;
    logic reset = 1'b1;
`ifdef DDR3_ARB_TIMEOUT_EN
    logic timeout_flag;
`endif
    int total = 0;
    int bad   = 0;

    ddr3_upload_arbiter_if #(.NREQ(3)) bus();

    ddr3_upload_arbiter #(.NREQ(3), .TIMEOUT_CYCLES(16'd16)) dut (
        .clk          (clk),
        .reset        (reset),
`ifdef DDR3_ARB_TIMEOUT_EN
        .timeout_flag (timeout_flag),
`endif
        .bus          (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  up;
        logic [2:0]  wr;
        logic        rdy;
        logic [2:0]  grant;
        logic        upl;
        logic        dwr;
        logic [2:0]  ready;
        logic        err;
        logic [27:0] addr;
    } vec_t;

    vec_t tv[19];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        bus.req_upload = '0;
        bus.req_wr     = '0;
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    initial begin
        int n;
        bus.req_addr[0] = A0; bus.req_addr[1] = A1; bus.req_addr[2] = A2;
        bus.req_din[0]  = 8'hA0; bus.req_din[1] = 8'hB1; bus.req_din[2] = 8'hC2;
        bus.req_upload  = '0;
        bus.req_wr      = '0;
        bus.ddr3_ready  = 1'b1;

        //          up      wr      rdy   grant   upl   dwr   ready   err   addr
        tv[0]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[1]  = '{3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[2]  = '{3'b001, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0, A0};
        tv[3]  = '{3'b001, 3'b000, 1'b0, 3'b001, 1'b1, 1'b0, 3'b000, 1'b0, A0};
        tv[4]  = '{3'b000, 3'b001, 1'b1, 3'b001, 1'b1, 1'b1, 3'b001, 1'b0, A0};
        tv[5]  = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[6]  = '{3'b111, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[7]  = '{3'b111, 3'b000, 1'b1, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, A1};
        tv[8]  = '{3'b101, 3'b000, 1'b1, 3'b010, 1'b1, 1'b0, 3'b010, 1'b0, A1};
        tv[9]  = '{3'b101, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[10] = '{3'b101, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[11] = '{3'b101, 3'b100, 1'b1, 3'b100, 1'b1, 1'b1, 3'b100, 1'b0, A2};
        tv[12] = '{3'b001, 3'b000, 1'b1, 3'b100, 1'b1, 1'b0, 3'b100, 1'b0, A2};
        tv[13] = '{3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[14] = '{3'b001, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b0, 28'h0};
        tv[15] = '{3'b001, 3'b100, 1'b1, 3'b001, 1'b1, 1'b0, 3'b001, 1'b0, A0};
        tv[16] = '{3'b000, 3'b000, 1'b1, 3'b001, 1'b1, 1'b0, 3'b001, 1'b1, A0};
        tv[17] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 28'h0};
        tv[18] = '{3'b000, 3'b000, 1'b1, 3'b000, 1'b0, 1'b0, 3'b000, 1'b1, 28'h0};

        do_reset();
        chk("reset_grant", 32'(bus.grant), 32'h0);
        chk("reset_upload", 32'(bus.ddr3_upload), 32'h0);
        chk("reset_wr_err", 32'(bus.wr_err), 32'h0);

        for (int i = 0; i < 19; i++) begin
            bus.req_upload = tv[i].up;
            bus.req_wr     = tv[i].wr;
            bus.ddr3_ready = tv[i].rdy;
            #1;
            chk($sformatf("v%0d_grant", i), 32'(bus.grant), 32'(tv[i].grant));
            chk($sformatf("v%0d_upload", i), 32'(bus.ddr3_upload), 32'(tv[i].upl));
            chk($sformatf("v%0d_ddr3_wr", i), 32'(bus.ddr3_wr), 32'(tv[i].dwr));
            chk($sformatf("v%0d_ready", i), 32'(bus.req_ready), 32'(tv[i].ready));
            chk($sformatf("v%0d_wr_err", i), 32'(bus.wr_err), 32'(tv[i].err));
            chk($sformatf("v%0d_addr", i), 32'(bus.ddr3_addr), 32'(tv[i].addr));
            tick();
        end

        // Reset mid-session with requester 1; rr_ptr is 1 beforehand.
        bus.req_wr = '0;
        bus.req_upload = 3'b010;
        tick();
        chk("midrst_pre_grant", 32'(bus.grant), 32'h2);
        #3;
        reset = 1'b1;
        #1;
        chk("midrst_grant_async", 32'(bus.grant), 32'h0);
        chk("midrst_upload_async", 32'(bus.ddr3_upload), 32'h0);
        chk("midrst_wr_err", 32'(bus.wr_err), 32'h0);
        tick();
        reset = 1'b0;

        // Contention from reset: rr_ptr back at 0, order 0,1,2.
        bus.req_upload = 3'b111;
        for (int k = 0; k < 3; k++) begin
            n = 0;
            while (bus.grant == 3'b000 && n < 8) begin
                tick();
                n++;
            end
            chk($sformatf("rr_grant_%0d", k), 32'(bus.grant), 32'(3'b001 << k));
            tick();
            bus.req_upload[k] = 1'b0;
            tick();
            chk($sformatf("rr_release_%0d", k), 32'(bus.grant), 32'h0);
        end

        // Single session: request raised in cycle 5 after reset.
        do_reset();
        for (int c = 0; c < 5; c++) tick();
        bus.req_upload = 3'b001;
        tick();
        chk("single_grant", 32'(bus.grant), 32'h1);
        chk("single_upload", 32'(bus.ddr3_upload), 32'h1);
        bus.req_wr = 3'b001;
        #1;
        chk("single_addr", 32'(bus.ddr3_addr), 32'(A0));
        chk("single_din", 32'(bus.ddr3_din), 32'hA0);
        chk("single_wr", 32'(bus.ddr3_wr), 32'h1);
        tick();
        bus.req_wr = '0;
        bus.req_upload = '0;
        tick();
        tick();

`ifdef DDR3_ARB_TIMEOUT_EN
        do_reset();
        bus.req_upload = 3'b011;
        tick();
        chk("to_first_grant", 32'(bus.grant), 32'h1);
        chk("to_flag_clear", 32'(timeout_flag), 32'h0);
        n = 0;
        while (bus.grant == 3'b001 && n < 40) begin
            tick();
            n++;
        end
        chk("to_grant_cycles", 32'(n), 32'd16);
        chk("to_release_grant", 32'(bus.grant), 32'h0);
        chk("to_flag_set", 32'(timeout_flag), 32'h1);
        n = 0;
        while (bus.grant == 3'b000 && n < 8) begin
            tick();
            n++;
        end
        chk("to_next_grant", 32'(bus.grant), 32'h2);
        bus.req_upload = '0;
        tick();
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/ddr3_upload_arbiter.md
DDR3_UPLOAD_ARBITER -- requirements
Module: ddr3_upload_arbiter

Interface
REQ-001 SHALL have parameter NREQ, default 3, number of upload requesters (fixed 2..4).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 16'hFFFF, idle-cycle limit while granted.
REQ-003 SHALL have port clk  input  1  system clock; all state on rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-005 SHALL have port req_addr  input  NREQ x 28  per-requester DDR3 byte address.
REQ-006 SHALL have port req_din  input  NREQ x 8  per-requester write data.
REQ-007 SHALL have port req_upload  input  NREQ  per-requester session request; held for the whole session.
REQ-008 SHALL have port req_wr  input  NREQ  per-requester one-cycle write strobe.
REQ-009 SHALL have port req_ready  output  NREQ  per-requester ready; equals ddr3_ready for the granted requester, else 0.
REQ-010 SHALL have port grant  output  NREQ  one-hot grant, registered.
REQ-011 SHALL have port ddr3_addr  output  28  muxed address from the granted requester, 0 when none is granted.
REQ-012 SHALL have port ddr3_din  output  8  muxed data from the granted requester, 0 when none is granted.
REQ-013 SHALL have port ddr3_upload  output  1  registered; high only in state GRANT.
REQ-014 SHALL have port ddr3_wr  output  1  req_wr of the granted requester, gated by grant.
REQ-015 SHALL have port ddr3_ready  input  1  DDR3 channel ready.
REQ-016 SHALL have port wr_err  output  1  sticky; set when any non-granted requester asserts req_wr.

Function
REQ-017 SHALL implement FSM states IDLE, GRANT, RELEASE.
REQ-018 IDLE: if any req_upload is high at edge N, SHALL enter GRANT with grant one-hot and ddr3_upload=1 from cycle N+1.
REQ-019 Selection SHALL be round-robin: search starts at pointer rr_ptr and wraps modulo NREQ; lowest index after rr_ptr wins among simultaneous requests.
REQ-020 GRANT: address, data and wr SHALL pass combinationally from the granted requester; no added latency.
REQ-021 GRANT: when the granted requester's req_upload samples low, SHALL enter RELEASE; grant and ddr3_upload clear on that edge.
REQ-022 A req_wr in the same cycle its req_upload falls SHALL still be forwarded, because grant is still high that cycle.
REQ-023 RELEASE SHALL last exactly one cycle with no grant, then go to IDLE; rr_ptr SHALL become (granted index + 1) mod NREQ.
REQ-024 A request arriving during GRANT or RELEASE SHALL wait; it is never dropped while req_upload stays high.
REQ-025 req_wr from a non-granted requester SHALL NOT reach ddr3_wr and SHALL set wr_err; only reset clears wr_err.
REQ-026 ddr3_ready low SHALL NOT stall the FSM; the requester owns the ready/wr handshake.

Reset
REQ-027 Asynchronous reset SHALL force state=IDLE, grant=0, ddr3_upload=0, rr_ptr=0, wr_err=0, timeout counter=0 and timeout_flag=0.
REQ-028 Reset asserted mid-session SHALL drop ddr3_upload and grant immediately, without waiting for a clock edge.

Configuration
REQ-029 Macro DDR3_ARB_TIMEOUT_EN defined: the block SHALL add output timeout_flag (1 bit, sticky).
REQ-030 With the macro defined, a 16-bit counter SHALL count GRANT cycles without ddr3_wr and reset on each ddr3_wr.
REQ-031 With the macro defined, when the counter reaches TIMEOUT_CYCLES the block SHALL force RELEASE and set timeout_flag.
REQ-032 After a forced RELEASE, the timed-out requester SHALL be regranted only when its turn comes round again.
REQ-033 Macro undefined: no counter and no timeout_flag port; a session lasts until req_upload falls.

Verification
REQ-034 Single session: req_upload[0] rises at cycle 5 -> grant=001 and ddr3_upload=1 at cycle 6; req_addr[0]=28'h1400000 with req_wr pulse appears on ddr3_addr and ddr3_wr in the same cycle.
REQ-035 Contention: req_upload=111 from reset -> grants in order 001, 010, 100, each separated by one RELEASE cycle with grant=000.
REQ-036 Illegal write: req_wr[2]=1 while grant=001 -> ddr3_wr=0 and wr_err=1 from the next cycle, held until reset.
REQ-037 Reset mid-session: reset pulsed during GRANT with requester 1 -> ddr3_upload=0 and grant=000 asynchronously; rr_ptr=0 afterwards.
REQ-038 Timeout (macro on, TIMEOUT_CYCLES=16): grant held with no wr for 16 cycles -> RELEASE, timeout_flag=1, next pending requester granted.
